// File: rtl/qspi_pkg.sv
// Shared definitions for the QSPI transmit path.
// Holds lane-mode encodings, the TX shifter state enumeration and small
// per-mode helpers (lane normalisation, bits per tick, pad output enables).
package qspi_pkg;

    localparam logic [1:0] MODE_SINGLE = 2'b00;
    localparam logic [1:0] MODE_DUAL   = 2'b01;
    localparam logic [1:0] MODE_QUAD   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_SHIFT = 2'd3
    } state_t;

    // Encoding 2'b11 is not a real mode and runs as single lane.
    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return ((m == MODE_DUAL) || (m == MODE_QUAD)) ? m : MODE_SINGLE;
    endfunction

    function automatic logic [2:0] bpt_for_mode(input logic [1:0] m);
        case (m)
            MODE_DUAL: return 3'd2;
            MODE_QUAD: return 3'd4;
            default:   return 3'd1;
        endcase
    endfunction

    function automatic logic [3:0] oe_for_mode(input logic [1:0] m);
        case (m)
            MODE_DUAL: return 4'b0011;
            MODE_QUAD: return 4'b1111;
            default:   return 4'b0001;
        endcase
    endfunction

endpackage

// File: rtl/qspi_tx_shifter_if.sv
// TX FIFO read port as seen by the shifter.
//   fifo_rd_en_o   : pop request (shifter -> FIFO)
//   fifo_rd_data_i : registered read data, valid the cycle after a pop
//   fifo_empty_i   : FIFO empty flag
interface qspi_tx_shifter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             fifo_rd_en_o;
    logic [WIDTH-1:0] fifo_rd_data_i;
    logic             fifo_empty_i;

    modport master (
        output fifo_rd_en_o,
        input  fifo_rd_data_i,
        input  fifo_empty_i
    );

    modport slave (
        input  fifo_rd_en_o,
        output fifo_rd_data_i,
        output fifo_empty_i
    );
endinterface

// File: rtl/qspi_tx_stage.sv
// One-entry prefetch register holding the next FIFO word while the current
// one is shifted out.
//   clk, reset      : clock, synchronous active-high reset
//   load_i, data_i  : capture a word and mark the entry valid
//   take_i          : consumer took the word, entry becomes empty
//   flush_i         : discard the entry
//   valid_o, data_o : entry state and contents
module qspi_tx_stage #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             take_i,
    input  logic             flush_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    // Flush wins over everything; load and take never coincide by construction.
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
        end else if (load_i) begin
            valid_o <= 1'b1;
            data_o  <= data_i;
        end else if (take_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: rtl/qspi_tx_shifter.sv
// QSPI transmit serializer: pops words from the TX FIFO and shifts them out on
// 1, 2 or 4 lanes, one bit-group per SCLK tick, byte 0 first, MSB first.
//   clk, reset             : clock, synchronous active-high reset
//   start_i, abort_i       : begin / cancel a transfer
//   mode_i, len_i          : lane mode and byte count, latched at start
//   tick_i                 : shift tick from the SCLK generator
//   fifo                   : TX FIFO read port (master side)
//   io_o, io_oe_o          : pad data and output enables
//   busy_o, ready_o        : transfer active / tick will be consumed
//   done_o, underrun_o     : completion pulse / sticky tick-starvation flag
//   bytes_left_o           : bytes not yet fully shifted
module qspi_tx_shifter
    import qspi_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_i,
    input  logic                     abort_i,
    input  logic [1:0]               mode_i,
    input  logic [CNT_W-1:0]         len_i,
    input  logic                     tick_i,
    qspi_tx_shifter_if.master        fifo,
    output logic [3:0]               io_o,
    output logic [3:0]               io_oe_o,
    output logic                     busy_o,
    output logic                     ready_o,
    output logic                     done_o,
    output logic                     underrun_o,
    output logic [CNT_W-1:0]         bytes_left_o
);

    localparam int unsigned BPW   = WIDTH / 8;
    localparam int unsigned IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

    state_t             state_q, state_d;
    logic [1:0]         mode_q;
    logic [WIDTH-1:0]   sh_q, sh_shift;
    logic [2:0]         bit_cnt_q;
    logic [IDX_W-1:0]   byte_idx_q;
    logic [CNT_W-1:0]   bytes_left_q, fetch_left_q;
    logic               inflight_q, underrun_q, done_q;

    logic               take, byte_done, last_byte, word_end, reload, rd_en;
    logic [3:0]         bit_sum;
    logic               stage_valid, stage_load, stage_take, stage_flush;
    logic [WIDTH-1:0]   stage_data;

    // Reorder a FIFO word so the next group to send always sits at the MSBs.
    function automatic logic [WIDTH-1:0] to_stream(input logic [WIDTH-1:0] w);
        logic [WIDTH-1:0] s;
        s = '0;
        for (int i = 0; i < int'(BPW); i++) begin
            s[WIDTH-1-8*i -: 8] = w[8*i +: 8];
        end
        return s;
    endfunction

    qspi_tx_stage #(.WIDTH(WIDTH)) u_stage (
        .clk     (clk),
        .reset   (reset),
        .load_i  (stage_load),
        .data_i  (fifo.fifo_rd_data_i),
        .take_i  (stage_take),
        .flush_i (stage_flush),
        .valid_o (stage_valid),
        .data_o  (stage_data)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_i && (len_i != '0)) state_d = ST_FETCH;
            ST_FETCH: begin
                if (abort_i)    state_d = ST_IDLE;
                else if (rd_en) state_d = ST_WAIT;
            end
            ST_WAIT:  state_d = abort_i ? ST_IDLE : ST_SHIFT;
            ST_SHIFT: begin
                if (abort_i)
                    state_d = ST_IDLE;
                else if (take && last_byte)
                    state_d = ST_IDLE;
                else if (take && word_end && !stage_valid && !inflight_q)
                    state_d = rd_en ? ST_WAIT : ST_FETCH;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs and datapath strobes.
    always_comb begin
        busy_o       = (state_q != ST_IDLE);
        ready_o      = (state_q == ST_SHIFT);
        done_o       = done_q;
        underrun_o   = underrun_q;
        bytes_left_o = bytes_left_q;
        take         = ready_o && tick_i && !abort_i;
        bit_sum      = 4'(bit_cnt_q) + 4'(bpt_for_mode(mode_q));
        byte_done    = take && bit_sum[3];
        last_byte    = byte_done && (bytes_left_q == CNT_W'(1));
        word_end     = byte_done && ((byte_idx_q == IDX_W'(BPW - 1)) || last_byte);

        // Prefetch only with an empty stage and nothing in flight so a
        // returning word always has somewhere to land.
        rd_en = 1'b0;
        if (!reset && !abort_i && (fetch_left_q != '0) && !fifo.fifo_empty_i) begin
            if (state_q == ST_FETCH)
                rd_en = 1'b1;
            else if ((state_q == ST_SHIFT) && !stage_valid && !inflight_q)
                rd_en = 1'b1;
        end

        // A word arriving from the FIFO this very cycle is bypassed straight
        // into the shift register when it is needed at a word boundary.
        reload      = take && word_end && !last_byte && (stage_valid || inflight_q);
        stage_take  = reload && stage_valid;
        stage_load  = ready_o && inflight_q && !reload && !abort_i;
        stage_flush = abort_i || (take && last_byte);

        io_o = 4'b0000;
        if (ready_o) begin
            case (mode_q)
                MODE_DUAL: io_o = {2'b00, sh_q[WIDTH-1 -: 2]};
                MODE_QUAD: io_o = sh_q[WIDTH-1 -: 4];
                default:   io_o = {3'b000, sh_q[WIDTH-1]};
            endcase
        end
        io_oe_o = busy_o ? oe_for_mode(mode_q) : 4'b0000;

        case (mode_q)
            MODE_DUAL: sh_shift = sh_q << 2;
            MODE_QUAD: sh_shift = sh_q << 4;
            default:   sh_shift = sh_q << 1;
        endcase
    end

    assign fifo.fifo_rd_en_o = rd_en;

    // Datapath: shift register, counters and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q       <= MODE_SINGLE;
            sh_q         <= '0;
            bit_cnt_q    <= '0;
            byte_idx_q   <= '0;
            bytes_left_q <= '0;
            fetch_left_q <= '0;
            inflight_q   <= 1'b0;
            underrun_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            inflight_q <= rd_en;
            done_q     <= 1'b0;
            if (state_q == ST_IDLE) begin
                if (start_i) begin
                    mode_q       <= norm_mode(mode_i);
                    bytes_left_q <= len_i;
                    fetch_left_q <= CNT_W'(({1'b0, len_i} + (CNT_W+1)'(BPW - 1)) / (CNT_W+1)'(BPW));
                    bit_cnt_q    <= '0;
                    byte_idx_q   <= '0;
                    underrun_q   <= 1'b0;
                    done_q       <= (len_i == '0);
                end
            end else if (abort_i) begin
                sh_q         <= '0;
                bytes_left_q <= '0;
                fetch_left_q <= '0;
            end else begin
                if (rd_en) fetch_left_q <= fetch_left_q - CNT_W'(1);
                if (tick_i && !ready_o) underrun_q <= 1'b1;
                if (state_q == ST_WAIT) begin
                    sh_q       <= to_stream(fifo.fifo_rd_data_i);
                    bit_cnt_q  <= '0;
                    byte_idx_q <= '0;
                end else if (take) begin
                    if (reload) begin
                        sh_q       <= to_stream(stage_valid ? stage_data : fifo.fifo_rd_data_i);
                        bit_cnt_q  <= '0;
                        byte_idx_q <= '0;
                    end else begin
                        sh_q      <= sh_shift;
                        bit_cnt_q <= bit_sum[2:0];
                        if (byte_done) byte_idx_q <= byte_idx_q + IDX_W'(1);
                    end
                    if (byte_done) bytes_left_q <= bytes_left_q - CNT_W'(1);
                    if (last_byte) done_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/qspi_tx_shifter.md
# qspi_tx_shifter

Transmit serializer between the TX FIFO and the QSPI IO pads. It pops 32-bit words from the TX FIFO, which has registered read data with 1-cycle latency, and shifts them out in single, dual or quad lane mode, one bit-group per SCLK shift tick. A one-word prefetch stage keeps consecutive words gapless. The block reports busy, done, ready and underrun status to the QSPI FSM.

## Interface
- WIDTH, 32, FIFO word width; must be a multiple of 8
- CNT_W, 16, width of the transfer byte count
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start_i  in  1  begin transfer; sampled only in IDLE
- abort_i  in  1  cancel transfer; return to IDLE next cycle with no done_o
- mode_i  in  2  lane mode: 00 single, 01 dual, 10 quad, 11 treated as single; latched at start
- len_i  in  CNT_W  bytes to send; latched at start
- tick_i  in  1  shift tick from the SCLK generator, one per falling edge
- fifo_rd_en_o  out  1  FIFO pop request
- fifo_rd_data_i  in  WIDTH  FIFO data; valid the cycle after fifo_rd_en_o
- fifo_empty_i  in  1  FIFO empty flag
- io_o  out  4  serial data to pads
- io_oe_o  out  4  pad output enables
- busy_o  out  1  transfer in progress
- ready_o  out  1  a tick this cycle will be consumed
- done_o  out  1  1-cycle pulse at normal completion
- underrun_o  out  1  sticky flag; cleared on accepted start_i
- bytes_left_o  out  CNT_W  bytes not yet fully shifted

## Operation
- **States:** IDLE, FETCH, WAIT, SHIFT.
- **IDLE:**
  - start_i with len_i == 0 stays in IDLE and pulses done_o the next cycle. No FIFO read occurs.
  - start_i with len_i > 0 goes to FETCH.
- **FETCH:** fifo_rd_en_o = !fifo_empty_i. When a read is issued, go to WAIT.
- **WAIT:** capture fifo_rd_data_i into the shift register, then go to SHIFT.
- **SHIFT:**
  - Bits per tick (bpt) is 1, 2 or 4.
  - Byte order within a word: byte 0 (bits [7:0]) first.
  - Bit order within a byte: MSB first.
  - Single mode: io_o[0] carries the bit.
  - Dual mode: io_o[1:0] carries the bit pair, higher bit on io_o[1].
  - Quad mode: io_o[3:0] carries the nibble.
  - Unused lanes drive 0.
- **Output enables:** io_oe_o is 0001, 0011 or 1111 per mode while in SHIFT, FETCH or WAIT mid-transfer, and 0000 in IDLE.
- **Prefetch:** in SHIFT, assert fifo_rd_en_o when all of the following hold:
  - the stage is empty;
  - no read is in flight;
  - !fifo_empty_i;
  - words_fetched < ceil(len/4).
  - The returning word lands in the stage.
- **Word boundary:** when a tick consumes the last group of a word, or the last needed byte:
  - Stage valid: load the shift register in the same cycle and stay in SHIFT. No ready_o gap.
  - Read in flight: go to WAIT.
  - Otherwise: go to FETCH.
- **Partial final word:** only len mod 4 bytes of the final word are sent; the remaining bytes are discarded.
- **Completion:** the tick that consumes the final group moves the FSM to IDLE next cycle and pulses done_o there. In that IDLE cycle busy_o is 0 and io_oe_o is 0.
- **Underrun:** a tick_i while busy_o && !ready_o sets underrun_o. That tick is ignored and the shifter does not advance.
- **Invalid inputs:** start_i while busy is ignored. tick_i in IDLE is ignored.
- **Abort or reset mid-transfer:**
  - Return to IDLE and discard the shift register and the stage.
  - Drop fifo_rd_en_o in the same cycle.
  - A word already popped is lost; it is not refilled.
- **Reset values:** all outputs 0; state IDLE; counters 0.

## Timing
- start_i sampled in cycle 0 with the FIFO non-empty:
  - cycle 1: FETCH, fifo_rd_en_o = 1.
  - cycle 2: WAIT, data captured.
  - cycle 3: SHIFT. ready_o = 1 and io_o presents the first group.
- A tick in cycle N advances io_o in cycle N+1.
- Groups per byte (8/bpt): 8 single, 4 dual, 2 quad.
- Ticks per transfer = len × 8 / bpt.
- bytes_left_o decrements on the tick that completes each byte.
- ready_o is 1 only in SHIFT.
- fifo_rd_en_o is never asserted while fifo_empty_i = 1.

## Structure
- Shared package qspi_pkg holds:
  - mode encodings MODE_SINGLE = 2'b00, MODE_DUAL = 2'b01, MODE_QUAD = 2'b10;
  - the state enumeration;
  - an oe_for_mode() function.
- One natural sub-module: qspi_tx_stage, a one-entry skid register with valid flag, load, take and flush.

## Test plan
- **Quad, len=4:** FIFO holds 0xA1B2C3D4 and one tick per cycle is applied from the first ready_o. Expect io_o nibble sequence D,4,C,3,B,2,A,1, then done_o 1 cycle after the 8th tick; io_oe_o = 1111 while shifting.
- **Single, len=1:** word 0x00000081. Expect io_o[0] = 1,0,0,0,0,0,0,1, 8 ticks, and bytes_left_o going 1→0 on the 8th tick.
- **Dual, len=10, gapless:** 3 words preloaded and ticks applied continuously. Expect ready_o to stay high across both word boundaries, exactly 3 pops, and bytes 2–3 of word 3 never driven.
- **Underrun:** quad, len=8, only 1 word in the FIFO, ticks applied continuously. Expect ready_o to drop after the 8th tick and underrun_o to set on the 9th tick. After a push, shifting resumes on the next word's byte 0 and done_o still follows 16 consumed ticks.
- **len=0 and abort:**
  - start_i with len=0: done_o pulses the next cycle and there is no pop.
  - abort_i mid-word: IDLE next cycle, io_oe_o = 0, no done_o.
- **Reset mid-transfer:** assert reset during SHIFT with the stage valid. Expect all outputs 0 the next cycle, and a new start_i to pop a fresh word with no stale data emitted.
